rgb2hsv_8u: RTL and testbench



---
 rtl/rgb_hsv_pkg.sv | 30 +++
 rtl/udiv_seq.sv | 63 ++++++
 rtl/rgb2hsv_8u.sv | 171 +++++++++++++++++
 tb/tb_rgb2hsv_8u.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_hsv_pkg.sv
// Shared types and constants for the RGB to HSV converter.
package rgb_hsv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV_S,
    DIV_H,
    HUE,
    OUT
  } state_t;

  // One load cycle plus one cycle per quotient bit
  localparam int DIV_CYCLES = 17;

  // Hue in sixths of a 256-step circle: each sector spans 256 units
  localparam logic [10:0] HUE_BASE_R = 11'd0;
  localparam logic [10:0] HUE_BASE_G = 11'd512;
  localparam logic [10:0] HUE_BASE_B = 11'd1024;
  localparam int          H6_WRAP    = 1536;

  // Pixel field offsets, {R,G,B} in and {H,S,V} out
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  localparam int H_LSB = 16;
  localparam int S_LSB = 8;
  localparam int V_LSB = 0;

endpackage

// File: rtl/udiv_seq.sv
// Restoring unsigned divider, 16-bit dividend by 8-bit divisor, one
// quotient bit per clock. done is high during the final iteration cycle;
// quotient holds the finished result from the following cycle onwards.
module udiv_seq
  import rgb_hsv_pkg::*;
#(
  parameter int ITERS = DIV_CYCLES - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);

  logic [7:0]  rem_q;
  logic [15:0] quo_q;
  logic [7:0]  dvs_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [8:0]  trial;
  logic [8:0]  diff;
  logic        fits;

  // Shift the next dividend bit into the remainder and try a subtraction
  always_comb begin
    trial = {rem_q, quo_q[15]};
    diff  = trial - {1'b0, dvs_q};
    fits  = (trial >= {1'b0, dvs_q});
  end

  // Load on start, then retire one quotient bit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= 5'(ITERS);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= fits ? diff[7:0] : trial[7:0];
      quo_q <= {quo_q[14:0], fits};
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == 5'd1);
  assign quotient = quo_q;

endmodule

// File: rtl/rgb2hsv_8u.sv
// 8-bit RGB to 8-bit HSV converter. One pixel in flight; saturation and
// hue fraction come from a single shared sequential divider.
module rgb2hsv_8u #(
  parameter int DIV_CYCLES = rgb_hsv_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] rgb_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] hsv_out
);

  import rgb_hsv_pkg::*;

  state_t state_q, state_d;

  logic [23:0] rgb_q;
  logic [7:0]  max_q, delta_q, num_abs_q, s_q;
  logic [10:0] base_q;
  logic        num_neg_q, gray_q;
  logic [23:0] hsv_q;

  logic [7:0]        r_c, g_c, b_c, max_c, min_c, delta_c, num_abs_c;
  logic [10:0]       base_c;
  logic signed [8:0] num_c, num_inv_c;

  logic [15:0] s_dividend, h_dividend, div_dividend, quotient;
  logic [7:0]  div_divisor;
  logic        div_start, div_busy, div_done;

  logic [8:0]  frac;
  logic [11:0] h6_pos, h6_neg, h6_raw, h_num, h_div;
  logic [7:0]  hue;

  logic unused_bits;

  // Pick the maximum channel (R wins ties, then G) and its signed hue numerator
  always_comb begin
    r_c    = rgb_q[R_LSB +: 8];
    g_c    = rgb_q[G_LSB +: 8];
    b_c    = rgb_q[B_LSB +: 8];
    max_c  = r_c;
    base_c = HUE_BASE_R;
    num_c  = $signed({1'b0, g_c}) - $signed({1'b0, b_c});
    if (r_c >= g_c && r_c >= b_c) begin
      max_c  = r_c;
      base_c = HUE_BASE_R;
      num_c  = $signed({1'b0, g_c}) - $signed({1'b0, b_c});
    end else if (g_c >= b_c) begin
      max_c  = g_c;
      base_c = HUE_BASE_G;
      num_c  = $signed({1'b0, b_c}) - $signed({1'b0, r_c});
    end else begin
      max_c  = b_c;
      base_c = HUE_BASE_B;
      num_c  = $signed({1'b0, r_c}) - $signed({1'b0, g_c});
    end
    min_c = r_c;
    if (g_c < min_c) min_c = g_c;
    if (b_c < min_c) min_c = b_c;
    delta_c   = max_c - min_c;
    num_inv_c = -num_c;
    num_abs_c = num_c[8] ? num_inv_c[7:0] : num_c[7:0];
  end

  // Rounded dividends: S = (255*delta + max/2)/max, frac = (256*|num| + delta/2)/delta
  always_comb begin
    s_dividend   = ({8'd0, delta_q} << 8) - {8'd0, delta_q} + {9'd0, max_q[7:1]};
    h_dividend   = {num_abs_q, 8'd0} + {9'd0, delta_q[7:1]};
    div_dividend = (state_q == DIV_H) ? h_dividend : s_dividend;
    div_divisor  = (state_q == DIV_H) ? delta_q : max_q;
    div_start    = ((state_q == DIV_S) || (state_q == DIV_H)) && !div_busy;
  end

  udiv_seq #(
    .ITERS(DIV_CYCLES - 1)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // Signed offset within the sector, wrapped onto the 0..1535 circle, then rounded to 0..255
  always_comb begin
    frac   = quotient[8:0];
    h6_pos = {1'b0, base_q} + {3'b0, frac};
    h6_neg = {1'b0, base_q} - {3'b0, frac};
    h6_raw = num_neg_q ? h6_neg : h6_pos;
    if (num_neg_q && ({2'b0, frac} > base_q)) begin
      h6_raw = h6_neg + 12'(H6_WRAP);
    end else if (h6_raw >= 12'(H6_WRAP)) begin
      h6_raw = h6_raw - 12'(H6_WRAP);
    end
    h_num = {1'b0, h6_raw[10:0]} + 12'd3;
    h_div = h_num / 12'd6;
    hue   = h_div[7:0];
  end

  assign unused_bits = ^{quotient[15:9], h6_raw[11], h_div[11:8]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing through prep, two divisions, hue and output hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = (delta_c == 8'd0) ? HUE : DIV_S;
      DIV_S:   if (div_done) state_d = DIV_H;
      DIV_H:   if (div_done) state_d = HUE;
      HUE:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel capture and per-stage datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q     <= '0;
      max_q     <= '0;
      delta_q   <= '0;
      num_abs_q <= '0;
      base_q    <= '0;
      num_neg_q <= 1'b0;
      gray_q    <= 1'b0;
      s_q       <= '0;
      hsv_q     <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        rgb_q <= rgb_in;
      end
      if (state_q == PREP) begin
        max_q     <= max_c;
        delta_q   <= delta_c;
        num_abs_q <= num_abs_c;
        base_q    <= base_c;
        num_neg_q <= num_c[8];
        gray_q    <= (delta_c == 8'd0);
      end
      if (state_q == DIV_H && !div_busy) begin
        s_q <= quotient[7:0];
      end
      if (state_q == HUE) begin
        hsv_q[V_LSB +: 8] <= max_q;
        hsv_q[S_LSB +: 8] <= gray_q ? 8'd0 : s_q;
        hsv_q[H_LSB +: 8] <= gray_q ? 8'd0 : hue;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign hsv_out   = hsv_q;

endmodule

// File: tb/tb_rgb2hsv_8u.sv
// Directed and randomised checks for rgb2hsv_8u.
module tb_rgb2hsv_8u;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] rgb_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] hsv_out;

  int n_tests = 0;
  int n_fail  = 0;

  rgb2hsv_8u #(.DIV_CYCLES(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rgb_in    (rgb_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hsv_out   (hsv_out)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference HSV straight from the arithmetic definition
  function automatic logic [23:0] model(input logic [23:0] p);
    int r, g, b, mx, mn, d, base, num, an, s, frac, h6, h;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (r >= g && r >= b) begin
      mx = r; base = 0; num = g - b;
    end else if (g >= b) begin
      mx = g; base = 512; num = b - r;
    end else begin
      mx = b; base = 1024; num = r - g;
    end
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    d  = mx - mn;
    if (d == 0) return {16'h0000, mx[7:0]};
    an   = (num < 0) ? -num : num;
    s    = (255 * d + mx / 2) / mx;
    frac = (256 * an + d / 2) / d;
    h6   = base + ((num < 0) ? -frac : frac);
    if (h6 < 0) h6 = h6 + 1536;
    h6 = h6 % 1536;
    h  = ((h6 + 3) / 6) % 256;
    return {h[7:0], s[7:0], mx[7:0]};
  endfunction

  // Push one pixel, wait (bounded) for the result, optionally consume it
  task automatic run_pixel(input logic [23:0] rgb, input bit consume,
                           output logic [23:0] hsv, output int lat);
    @(negedge clk);
    rgb_in   = rgb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    hsv = hsv_out;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_tests++;
    if (hsv_out !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL reset_hsv_out: got %h expected 000000", hsv_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_primaries_ties_wrap();
    logic [23:0] vin [5];
    logic [23:0] vexp [5];
    logic [23:0] got;
    int lat;
    vin  = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF0080};
    vexp = '{24'h00FFFF, 24'h55FFFF, 24'hABFFFF, 24'h2BFFFF, 24'hEBFFFF};
    for (int i = 0; i < 5; i++) begin
      run_pixel(vin[i], 1'b1, got, lat);
      n_tests++;
      if (got !== vexp[i]) begin
        n_fail++; $display("[TB] FAIL chroma_hsv rgb=%h: got %h expected %h", vin[i], got, vexp[i]);
      end
      n_tests++;
      if (lat != 36) begin
        n_fail++; $display("[TB] FAIL chroma_latency rgb=%h: got %0d expected 36", vin[i], lat);
      end
    end
  endtask

  task automatic test_gray();
    logic [23:0] got;
    int lat;
    run_pixel(24'h808080, 1'b1, got, lat);
    n_tests++;
    if (got !== 24'h000080) begin
      n_fail++; $display("[TB] FAIL gray_hsv: got %h expected 000080", got);
    end
    n_tests++;
    if (lat != 2) begin
      n_fail++; $display("[TB] FAIL gray_latency: got %0d expected 2", lat);
    end
    run_pixel(24'h000000, 1'b1, got, lat);
    n_tests++;
    if (got !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL black_hsv: got %h expected 000000", got);
    end
    n_tests++;
    if (lat != 2) begin
      n_fail++; $display("[TB] FAIL black_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit saw_ready;
    bit unstable;
    bit ready_hold;
    @(negedge clk);
    rgb_in   = 24'h00FF00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat       = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat != 36) begin
      n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 36", lat);
    end
    n_tests++;
    if (saw_ready) begin
      n_fail++; $display("[TB] FAIL busy_in_ready: got 1 expected 0 while processing");
    end
    rgb_in     = 24'h102030;
    in_valid   = 1'b1;
    unstable   = 1'b0;
    ready_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (hsv_out !== 24'h55FFFF || out_valid !== 1'b1) unstable = 1'b1;
      if (in_ready !== 1'b0) ready_hold = 1'b1;
    end
    n_tests++;
    if (unstable) begin
      n_fail++; $display("[TB] FAIL bp_hold: got hsv %h valid %b expected 55ffff valid 1", hsv_out, out_valid);
    end
    n_tests++;
    if (ready_hold) begin
      n_fail++; $display("[TB] FAIL bp_in_ready: got 1 expected 0 during hold");
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_release: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_no_accept: got in_ready %b expected 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    int lat;
    bit spurious;
    @(negedge clk);
    rgb_in   = 24'hFF0080;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_flags: got ready %b valid %b expected 1 0", in_ready, out_valid);
    end
    n_tests++;
    if (hsv_out !== 24'h000000) begin
      n_fail++; $display("[TB] FAIL midreset_hsv: got %h expected 000000", hsv_out);
    end
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    n_tests++;
    if (spurious) begin
      n_fail++; $display("[TB] FAIL midreset_stale: got out_valid 1 expected 0");
    end
    run_pixel(24'h0000FF, 1'b1, got, lat);
    n_tests++;
    if (got !== 24'hABFFFF || lat != 36) begin
      n_fail++; $display("[TB] FAIL midreset_next: got %h lat %0d expected abffff lat 36", got, lat);
    end
  endtask

  task automatic test_random();
    logic [23:0] p, got, exp_hsv;
    int lat, exp_lat;
    for (int i = 0; i < 200; i++) begin
      p = 24'($urandom);
      if (i % 10 == 0) p = {p[7:0], p[7:0], p[7:0]};
      exp_hsv = model(p);
      exp_lat = (p[23:16] == p[15:8] && p[15:8] == p[7:0]) ? 2 : 36;
      run_pixel(p, 1'b1, got, lat);
      n_tests++;
      if (got !== exp_hsv) begin
        n_fail++; $display("[TB] FAIL random_hsv rgb=%h: got %h expected %h", p, got, exp_hsv);
      end
      n_tests++;
      if (lat != exp_lat) begin
        n_fail++; $display("[TB] FAIL random_latency rgb=%h: got %0d expected %0d", p, lat, exp_lat);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rgb_in    = '0;
    test_reset();
    test_primaries_ties_wrap();
    test_gray();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
